// File: rtl/fft_stream_seq.sv
// Input-side sequencer for the 128-point radix-2 SDF FFT: frames the sample stream into valid/cnt,
// keeps cnt running while the pipe drains, and regenerates output framing aligned with the last stage.
module fft_stream_seq #(
   parameter int N_LOG2   = 7,
   parameter int PIPE_LAT = 134
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              din_valid,
   input  logic              din_sof,
   output logic              din_ready,
   input  logic              err_clr,
   output logic              valid,
   output logic [N_LOG2-1:0] cnt,
   output logic              dout_valid,
   output logic              dout_sof,
   output logic              dout_eof,
   output logic [N_LOG2-1:0] dout_idx,
   output logic              busy,
   output logic              err_gap,
   output logic              err_sof
);

   localparam int FRAME = 1 << N_LOG2;
   localparam int Q     = PIPE_LAT / FRAME;
   localparam int R     = PIPE_LAT % FRAME;
   localparam int HW    = Q + 1;
   localparam logic [N_LOG2-1:0] LAST       = N_LOG2'(FRAME - 1);
   localparam logic [N_LOG2-1:0] R_C        = N_LOG2'(R);
   localparam logic [9:0]        DRAIN_LOAD = 10'(PIPE_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              valid_q, valid_d;
   logic [N_LOG2-1:0] cnt_q, cnt_d;
   logic [9:0]        drain_q, drain_d;
   logic [HW-1:0]     hist_q, hist_d;
   logic              err_gap_q, err_gap_d;
   logic              err_sof_q, err_sof_d;
   logic              ready;
   logic              at_last;
   logic              gap_set;
   logic              sof_set;
   logic [N_LOG2-1:0] out_cnt;
   logic [N_LOG2-1:0] out_rev;
   logic              out_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         drain_q   <= '0;
         hist_q    <= '0;
         err_gap_q <= 1'b0;
         err_sof_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         drain_q   <= drain_d;
         hist_q    <= hist_d;
         err_gap_q <= err_gap_d;
         err_sof_q <= err_sof_d;
      end
   end

   // Handshake: a sample is taken when din_valid & din_ready; anything offered while din_ready is low is silently dropped.
   always_comb begin
      state_d = state_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      drain_d = drain_q;
      ready   = 1'b0;
      gap_set = 1'b0;
      sof_set = 1'b0;
      at_last = (cnt_q == LAST);
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            cnt_d = '0;
            if (din_valid) begin
               if (din_sof) begin
                  state_d = RUN;
                  valid_d = 1'b1;
               end else begin
                  sof_set = 1'b1;
               end
            end
         end
         RUN: begin
            ready = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (!at_last) begin
               if (!din_valid) begin
                  gap_set = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  valid_d = 1'b1;
                  sof_set = din_sof;
               end
            end else if (din_valid && din_sof) begin
               valid_d = 1'b1;
            end else begin
               sof_set = din_valid;
               state_d = DRAIN;
               drain_d = DRAIN_LOAD;
            end
         end
         DRAIN: begin
            ready = at_last;
            cnt_d = cnt_q + 1'b1;
            if (at_last && din_valid && din_sof) begin
               state_d = RUN;
               valid_d = 1'b1;
            end else begin
               sof_set = at_last && din_valid;
               if (drain_q == '0) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // While busy, cnt advances every cycle, so frames always start on a fixed 2^N_LOG2 slot grid.
   // hist_q[j-1] records whether the slot j slots back carried a frame; that is all the output side needs.
   always_comb begin
      hist_d = hist_q;
      if (state_q != IDLE && at_last)
         hist_d = {hist_q[HW-2:0], valid_q};
      if (state_d == IDLE)
         hist_d = '0;
   end

   always_comb begin
      err_gap_d = gap_set | (err_gap_q & ~err_clr);
      err_sof_d = sof_set | (err_sof_q & ~err_clr);
   end

   // The slot now leaving the last stage is Q slots back, or Q+1 until cnt passes the latency remainder.
   always_comb begin
      out_cnt   = cnt_q - R_C;
      out_valid = (cnt_q >= R_C) ? hist_q[Q-1] : hist_q[Q];
      out_rev   = '0;
      for (int i = 0; i < N_LOG2; i++)
         out_rev[i] = out_cnt[N_LOG2-1-i];
   end

   assign din_ready  = ready & reset_n;
   assign valid      = valid_q;
   assign cnt        = cnt_q;
   assign dout_valid = out_valid;
   assign dout_sof   = out_valid && (out_cnt == '0);
   assign dout_eof   = out_valid && (out_cnt == LAST);
   assign dout_idx   = out_valid ? out_rev : '0;
   assign busy       = (state_q != IDLE);
   assign err_gap    = err_gap_q;
   assign err_sof    = err_sof_q;

endmodule
